// File: rtl/rx_fcs_pkg.sv
// Shared types and CRC helpers for the receive FCS checker.
// The generic bit step is written for widths up to 32 bits.
package rx_fcs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fcs_state_t;

  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

  // Non-premultiplied serial step: the incoming bit is folded in at the MSB feedback tap.
  function automatic logic [31:0] crc_step(
    input logic [31:0] crc,
    input logic        b,
    input logic [31:0] poly,
    input int unsigned w
  );
    logic        fb;
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    fb   = crc[5'(w - 1)] ^ b;
    return ((crc << 1) ^ (fb ? poly : 32'd0)) & mask;
  endfunction

endpackage

// File: rtl/rx_destuff.sv
// Tracks runs of raw ones and suppresses the stuffed zero that follows
// STUFF_RUN consecutive ones; o_BitAcc marks bits the CRC should consume.
module rx_destuff
  import rx_fcs_pkg::*;
#(
  parameter int unsigned STUFF_RUN = 5
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Rx,
  input  logic i_BitEn,
  input  logic i_Start,
  input  logic i_Run,
  output logic o_BitAcc
);

  localparam int unsigned   CW      = (STUFF_RUN == 0) ? 1 : $clog2(STUFF_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(STUFF_RUN);

  logic [CW-1:0] r_cnt;
  logic          w_stuffHit;

  assign w_stuffHit = (STUFF_RUN != 0) && (r_cnt == RUN_MAX);

  // The first bit of a frame is never a stuffed bit, whatever the old count was.
  assign o_BitAcc = i_BitEn & (i_Start | (i_Run & ~w_stuffHit));

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_cnt <= '0;
    end else if (i_Start) begin
      r_cnt <= (STUFF_RUN != 0) ? CW'(i_BitEn & i_Rx) : '0;
    end else if (i_Run) begin
      if (i_BitEn) begin
        if (w_stuffHit) begin
          r_cnt <= '0;
        end else if (i_Rx) begin
          if (r_cnt != RUN_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/rx_fcs_chk.sv
// Receive FCS checker: bit-serial CRC over the destuffed stream, residue check at StopFCS.
// Optional saturating error counter enabled by defining RXFCS_ERRCNT_EN.
module rx_fcs_chk
  import rx_fcs_pkg::*;
#(
  parameter int unsigned      FCS_W     = 16,
  parameter logic [FCS_W-1:0] POLY      = FCS_W'(CRC16_CCITT_POLY),
  parameter logic [FCS_W-1:0] INIT      = '0,
  parameter logic [FCS_W-1:0] RESIDUE   = '0,
  parameter int unsigned      STUFF_RUN = 5
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Rx,
  input  logic             i_BitEn,
  input  logic             i_StartFCS,
  input  logic             i_StopFCS,
  input  logic             i_Abort,
  input  logic             i_FCSen,
`ifdef RXFCS_ERRCNT_EN
  input  logic             i_ErrCntClr,
  output logic [7:0]       o_ErrCnt,
`endif
  output logic [FCS_W-1:0] o_FCSval,
  output logic             o_FCSdone,
  output logic             o_FCSerr
);

  fcs_state_t       r_state;
  fcs_state_t       w_stateNext;
  logic [FCS_W-1:0] r_fcs;
  logic [FCS_W-1:0] w_fcsNext;
  logic             r_done;
  logic             w_doneNext;
  logic             r_err;
  logic             w_errNext;
  logic             w_start;
  logic             w_run;
  logic             w_bitAcc;

  function automatic logic [FCS_W-1:0] stepW(input logic [FCS_W-1:0] crc, input logic b);
    logic [31:0] t;
    t = crc_step(32'(crc), b, 32'(POLY), FCS_W);
    return t[FCS_W-1:0];
  endfunction

  // Abort and StopFCS outrank a restart while a frame is running.
  assign w_start = i_StartFCS & ((r_state == IDLE) | (~i_Abort & ~i_StopFCS));
  assign w_run   = (r_state == RUN) & ~i_Abort & ~i_StopFCS;

  rx_destuff #(
    .STUFF_RUN(STUFF_RUN)
  ) u_destuff (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Rx    (i_Rx),
    .i_BitEn (i_BitEn),
    .i_Start (w_start),
    .i_Run   (w_run),
    .o_BitAcc(w_bitAcc)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (i_StartFCS) w_stateNext = RUN;
      RUN:     if (i_Abort || i_StopFCS) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // The register is held on the StopFCS edge so FCSval still shows the checked value;
  // the IDLE branch reloads INIT on the following edge.
  always_comb begin
    w_fcsNext  = r_fcs;
    w_doneNext = 1'b0;
    w_errNext  = r_err;
    case (r_state)
      IDLE: begin
        w_fcsNext = INIT;
        if (i_StartFCS) begin
          w_errNext = 1'b0;
          if (w_bitAcc) w_fcsNext = stepW(INIT, i_Rx);
        end
      end
      RUN: begin
        if (i_Abort) begin
          w_fcsNext = INIT;
          w_errNext = 1'b0;
        end else if (i_StopFCS) begin
          w_doneNext = 1'b1;
          w_errNext  = i_FCSen && (r_fcs != RESIDUE);
        end else if (i_StartFCS) begin
          w_errNext = 1'b0;
          w_fcsNext = w_bitAcc ? stepW(INIT, i_Rx) : INIT;
        end else if (w_bitAcc) begin
          w_fcsNext = stepW(r_fcs, i_Rx);
        end
      end
      default: begin
        w_fcsNext = INIT;
        w_errNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_fcs  <= INIT;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_fcs  <= w_fcsNext;
      r_done <= w_doneNext;
      r_err  <= w_errNext;
    end
  end

  assign o_FCSval  = r_fcs;
  assign o_FCSdone = r_done;
  assign o_FCSerr  = r_err;

`ifdef RXFCS_ERRCNT_EN
  logic [7:0] r_errCnt;

  // Counts on the visible done pulse; a clear in the same cycle takes precedence.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_errCnt <= 8'd0;
    end else if (i_ErrCntClr) begin
      r_errCnt <= 8'd0;
    end else if (r_done && r_err && (r_errCnt != 8'hFF)) begin
      r_errCnt <= r_errCnt + 8'd1;
    end
  end

  assign o_ErrCnt = r_errCnt;
`endif

endmodule

// File: tb/tb_rx_fcs_chk.sv
// Directed bench for rx_fcs_chk: a 16-bit default instance and a 32-bit instance share stimulus.
// Error-counter checks are compiled only when RXFCS_ERRCNT_EN is defined.
module tb_rx_fcs_chk;
  import rx_fcs_pkg::*;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        rx       = 1'b0;
  logic        bitEn    = 1'b0;
  logic        startFcs = 1'b0;
  logic        stopFcs  = 1'b0;
  logic        abort    = 1'b0;
  logic        fcsEn    = 1'b1;
  logic [15:0] fcsVal16;
  logic        done16;
  logic        err16;
  logic [31:0] fcsVal32;
  logic        done32;
  logic        err32;
`ifdef RXFCS_ERRCNT_EN
  logic        errCntClr = 1'b0;
  logic [7:0]  errCnt16;
  logic [7:0]  errCnt32;
`endif

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  rx_fcs_chk dut16 (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Rx       (rx),
    .i_BitEn    (bitEn),
    .i_StartFCS (startFcs),
    .i_StopFCS  (stopFcs),
    .i_Abort    (abort),
    .i_FCSen    (fcsEn),
`ifdef RXFCS_ERRCNT_EN
    .i_ErrCntClr(errCntClr),
    .o_ErrCnt   (errCnt16),
`endif
    .o_FCSval   (fcsVal16),
    .o_FCSdone  (done16),
    .o_FCSerr   (err16)
  );

  rx_fcs_chk #(
    .FCS_W(32),
    .POLY (CRC32_POLY)
  ) dut32 (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Rx       (rx),
    .i_BitEn    (bitEn),
    .i_StartFCS (startFcs),
    .i_StopFCS  (stopFcs),
    .i_Abort    (abort),
    .i_FCSen    (fcsEn),
`ifdef RXFCS_ERRCNT_EN
    .i_ErrCntClr(errCntClr),
    .o_ErrCnt   (errCnt32),
`endif
    .o_FCSval   (fcsVal32),
    .o_FCSdone  (done32),
    .o_FCSerr   (err32)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs after a falling edge and returns at the next falling edge.
  task automatic applyStimulus(input logic st, input logic sp, input logic ab,
                               input logic en, input logic b);
    startFcs = st;
    stopFcs  = sp;
    abort    = ab;
    bitEn    = en;
    rx       = b;
    @(negedge clk);
  endtask

  // Leading 1 then 16'h1021 MSB-first: the remainder of that single 1 bit, so residue 0.
  task automatic sendFrame16(input logic flipLast);
    logic [15:0] v;
    logic        b;
    v = 16'h1021;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 15; i >= 0; i--) begin
      b = v[i];
      if (i == 0 && flipLast) b = ~b;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, b);
    end
  endtask

  task automatic sendFrame32();
    logic [31:0] v;
    v = CRC32_POLY;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 31; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, v[i]);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst.fcs16", 32'(fcsVal16), 32'h0);
    checkOutput("rst.done16", 32'(done16), 32'h0);
    checkOutput("rst.err16", 32'(err16), 32'h0);
    checkOutput("rst.cnt16", 32'(dut16.u_destuff.r_cnt), 32'd0);
    checkOutput("rst.fcs32", 32'(fcsVal32), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("idle.stopIgnored", 32'(done16), 32'h0);

    // Good frame
    sendFrame16(1'b0);
    checkOutput("good.fcsPreStop", 32'(fcsVal16), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("good.done", 32'(done16), 32'h1);
    checkOutput("good.err", 32'(err16), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("good.donePulse", 32'(done16), 32'h0);

    // Last bit flipped: residue becomes x^16 mod G = 0x1021
    sendFrame16(1'b1);
    checkOutput("bad.fcsPreStop", 32'(fcsVal16), 32'h1021);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("bad.done", 32'(done16), 32'h1);
    checkOutput("bad.err", 32'(err16), 32'h1);
    checkOutput("bad.fcsHeld", 32'(fcsVal16), 32'h1021);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bad.errSticky", 32'(err16), 32'h1);
    checkOutput("bad.fcsReload", 32'(fcsVal16), 32'h0);
    checkOutput("bad.doneLow", 32'(done16), 32'h0);
`ifdef RXFCS_ERRCNT_EN
    checkOutput("errcnt.one", 32'(errCnt16), 32'd1);
`endif

    // Bad frame with reporting disabled
    fcsEn = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("start.errClear", 32'(err16), 32'h0);
    sendFrame16(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("dis.done", 32'(done16), 32'h1);
    checkOutput("dis.err", 32'(err16), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef RXFCS_ERRCNT_EN
    checkOutput("errcnt.noInc", 32'(errCnt16), 32'd1);
`endif
    fcsEn = 1'b1;

    // Five ones, then the stuffed zero is dropped
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("stuff.fcs5", 32'(fcsVal16), 32'hE3DE);
    checkOutput("stuff.cnt5", 32'(dut16.u_destuff.r_cnt), 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("stuff.dropHold", 32'(fcsVal16), 32'hE3DE);
    checkOutput("stuff.cntClr", 32'(dut16.u_destuff.r_cnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("stuff.nextAcc", 32'(fcsVal16), 32'hC7BC);
    checkOutput("stuff.cnt1", 32'(dut16.u_destuff.r_cnt), 32'd1);

    // Idle gap then Abort together with StopFCS
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("gap.fcsHeld", 32'(fcsVal16), 32'hC7BC);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("abort.done", 32'(done16), 32'h0);
    checkOutput("abort.err", 32'(err16), 32'h0);
    checkOutput("abort.fcs", 32'(fcsVal16), 32'h0);
    checkOutput("abort.cnt", 32'(dut16.u_destuff.r_cnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort.doneLater", 32'(done16), 32'h0);

    // Restart while running reseeds from INIT
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("restart.first0", 32'(fcsVal16), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("restart.bit1", 32'(fcsVal16), 32'h1021);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("restart.reseed", 32'(fcsVal16), 32'h1021);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef RXFCS_ERRCNT_EN
    for (int k = 0; k < 2; k++) begin
      sendFrame16(1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("errcnt.three", 32'(errCnt16), 32'd3);
    sendFrame16(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("errcnt.done4", 32'(done16 & err16), 32'h1);
    errCntClr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    errCntClr = 1'b0;
    checkOutput("errcnt.clrWins", 32'(errCnt16), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("errcnt.stay0", 32'(errCnt16), 32'd0);
`endif

    // 32-bit instance
    sendFrame32();
    checkOutput("crc32.fcsPreStop", fcsVal32, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("crc32.done", 32'(done32), 32'h1);
    checkOutput("crc32.err", 32'(err32), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mid.fcs32", fcsVal32, 32'h17C56B6B);
    checkOutput("mid.fcs16", 32'(fcsVal16), 32'h50A5);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst.fcs32", fcsVal32, 32'h0);
    checkOutput("arst.fcs16", 32'(fcsVal16), 32'h0);
    checkOutput("arst.cnt16", 32'(dut16.u_destuff.r_cnt), 32'd0);
    checkOutput("arst.done", 32'(done16 | done32), 32'h0);
    checkOutput("arst.err", 32'(err16 | err32), 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("arst.idleHold", 32'(fcsVal16), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
